// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: shares the single FPRO MMIO bus between two masters.
// Master 0 is the processor core. Master 1 is a secondary master, such as a
// debug loader or a DMA engine.
// A request is sampled in IDLE and replayed as one registered bus cycle in
// ISSUE. It is acknowledged in ACK, and read data is returned with the ack.
// When both masters request, they alternate round-robin.
// Optional build macro MMIO_ARB_STATS_EN adds saturating per-master ack
// counters (m0_count/m1_count) and a synchronous stats_clr input.
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (processor core)
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    // master 1 (secondary bus master)
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    // shared MMIO bus
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
`ifdef MMIO_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       m0_count,
    output logic [15:0]       m1_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]        state;
    logic              last_grant;  // master served most recently
    logic              cur;         // master owning the transaction in flight

    logic              grant;
    logic              sel_wr;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wr_data;

    // A lone requester wins. When both request, the master that was not
    // served last wins.
    assign grant       = (m0_req && m1_req) ? ~last_grant : m1_req;
    assign sel_wr      = grant ? m1_wr      : m0_wr;
    assign sel_rd      = grant ? m1_rd      : m0_rd;
    assign sel_addr    = grant ? m1_addr    : m0_addr;
    assign sel_wr_data = grant ? m1_wr_data : m0_wr_data;

    // FSM, registered bus outputs, acks and captured read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout, so every register
            // reads the pre-edge value of the others regardless of order.
            state        <= IDLE;
            last_grant   <= 1'b1;
            cur          <= 1'b0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= '0;
            m1_rd_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state        <= ISSUE;
                        cur          <= grant;
                        last_grant   <= grant;
                        // An empty command leaves cs low. A write wins over a read.
                        mmio_cs      <= sel_wr | sel_rd;
                        mmio_wr      <= sel_wr;
                        mmio_rd      <= sel_rd & ~sel_wr;
                        mmio_addr    <= sel_addr;
                        mmio_wr_data <= sel_wr_data;
                    end
                end
                ISSUE: begin
                    state   <= ACK;
                    mmio_cs <= 1'b0;
                    mmio_wr <= 1'b0;
                    mmio_rd <= 1'b0;
                    // Reads capture bus data and empty commands return zero.
                    // Writes leave the last read value in place.
                    if (cur) begin
                        m1_ack <= 1'b1;
                        if (mmio_rd)       m1_rd_data <= mmio_rd_data;
                        else if (!mmio_cs) m1_rd_data <= '0;
                    end else begin
                        m0_ack <= 1'b1;
                        if (mmio_rd)       m0_rd_data <= mmio_rd_data;
                        else if (!mmio_cs) m0_rd_data <= '0;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MMIO_ARB_STATS_EN
    // Per-master ack counters: saturate at all-ones, and a clear wins over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_count <= '0;
            m1_count <= '0;
        end else if (stats_clr) begin
            m0_count <= '0;
            m1_count <= '0;
        end else begin
            if (m0_ack && (m0_count != 16'hFFFF)) m0_count <= m0_count + 16'd1;
            if (m1_ack && (m1_count != 16'hFFFF)) m1_count <= m1_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench for mmio_bus_arbiter.
// Inputs are driven and outputs are sampled on the falling clock edge. Each
// negedge therefore sits in the middle of one cycle.
module tb_mmio_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_wr, m0_rd;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;
    logic              m1_req, m1_wr, m1_rd;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;
    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;
`ifdef MMIO_ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       m0_count, m1_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // expected read-data register contents per master
    logic [DATA_W-1:0] model_rd [2];

    always #5 clk = ~clk;

    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_wr        (m0_wr),
        .m0_rd        (m0_rd),
        .m0_addr      (m0_addr),
        .m0_wr_data   (m0_wr_data),
        .m0_ack       (m0_ack),
        .m0_rd_data   (m0_rd_data),
        .m1_req       (m1_req),
        .m1_wr        (m1_wr),
        .m1_rd        (m1_rd),
        .m1_addr      (m1_addr),
        .m1_wr_data   (m1_wr_data),
        .m1_ack       (m1_ack),
        .m1_rd_data   (m1_rd_data),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data)
`ifdef MMIO_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .m0_count     (m0_count),
        .m1_count     (m1_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic drive_master(input bit m, input logic req, input logic wr, input logic rd,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (m) begin
            m1_req = req; m1_wr = wr; m1_rd = rd; m1_addr = addr; m1_wr_data = wdata;
        end else begin
            m0_req = req; m0_wr = wr; m0_rd = rd; m0_addr = addr; m0_wr_data = wdata;
        end
    endtask

    // One lone-master transaction: request (IDLE), bus cycle (ISSUE), ack (ACK).
    task automatic txn(input string tag, input bit m, input logic wr, input logic rd,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [DATA_W-1:0] bus_rdata);
        @(negedge clk);
        drive_master(m, 1'b1, wr, rd, addr, wdata);
        @(negedge clk);
        check({tag, "_cs"},   mmio_cs, wr | rd);
        check({tag, "_wr"},   mmio_wr, wr);
        check({tag, "_rd"},   mmio_rd, rd & ~wr);
        check({tag, "_addr"}, mmio_addr, addr);
        if (wr) check({tag, "_wdata"}, mmio_wr_data, wdata);
        check({tag, "_early_ack"}, {m0_ack, m1_ack}, 2'b00);
        mmio_rd_data = bus_rdata;
        if (!wr) model_rd[m] = rd ? bus_rdata : '0;
        @(negedge clk);
        check({tag, "_ack0"}, m0_ack, !m);
        check({tag, "_ack1"}, m1_ack, m);
        check({tag, "_rdata0"}, m0_rd_data, model_rd[0]);
        check({tag, "_rdata1"}, m1_rd_data, model_rd[1]);
        check({tag, "_cs_off"}, mmio_cs, 1'b0);
        drive_master(m, 1'b0, 1'b0, 1'b0, '0, '0);
        mmio_rd_data = '0;
    endtask

    initial begin
        int n0;
        int n1;
        rst = 1'b1;
        drive_master(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        mmio_rd_data = '0;
        model_rd[0] = '0;
        model_rd[1] = '0;
`ifdef MMIO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_cs",     mmio_cs, 1'b0);
        check("rst_strobe", {mmio_wr, mmio_rd}, 2'b00);
        check("rst_addr",   mmio_addr, '0);
        check("rst_acks",   {m0_ack, m1_ack}, 2'b00);
        check("rst_rdata",  {m0_rd_data, m1_rd_data}, 64'h0);
        rst = 1'b0;

        // basic write from m0, then read by m1
        txn("m0_write", 1'b0, 1'b1, 1'b0, 21'h000C0, 32'hA5A5_0001, 32'h0);
        txn("m1_read",  1'b1, 1'b0, 1'b1, 21'h00180, 32'h0, 32'h0000_000F);

        // both masters requesting continuously: alternate starting with m0
        @(negedge clk);
        drive_master(1'b0, 1'b1, 1'b1, 1'b0, 21'h00010, 32'h1111_0000);
        drive_master(1'b1, 1'b1, 1'b1, 1'b0, 21'h00020, 32'h2222_0000);
        n0 = 0;
        n1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("rr_ack0_c%0d", c), m0_ack, (c == 2) || (c == 8));
            check($sformatf("rr_ack1_c%0d", c), m1_ack, (c == 5) || (c == 11));
            n0 += int'(m0_ack);
            n1 += int'(m1_ack);
        end
        drive_master(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("rr_total_acks", n0 + n1, 4);

        // read, then wr+rd (acts as write, rd_data kept), then empty command
        txn("m0_read",   1'b0, 1'b0, 1'b1, 21'h00044, 32'h0, 32'hDEAD_BEEF);
        txn("m0_wr_rd",  1'b0, 1'b1, 1'b1, 21'h00048, 32'hCAFE_0002, 32'h0000_1234);
        txn("m0_empty",  1'b0, 1'b0, 1'b0, 21'h0004C, 32'h0, 32'h5555_5555);

        // reset during ISSUE of an m1 write aborts the transaction
        @(negedge clk);
        drive_master(1'b1, 1'b1, 1'b1, 1'b0, 21'h00100, 32'h0BAD_0BAD);
        @(negedge clk);
        check("abort_cs_before", mmio_cs, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_cs_async", mmio_cs, 1'b0);
        check("abort_wr_async", mmio_wr, 1'b0);
        @(negedge clk);
        check("abort_no_ack1", m1_ack, 1'b0);
        drive_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        model_rd[0] = '0;
        model_rd[1] = '0;
        rst = 1'b0;
        @(negedge clk);
        drive_master(1'b0, 1'b1, 1'b1, 1'b0, 21'h00200, 32'h0000_00AA);
        drive_master(1'b1, 1'b1, 1'b1, 1'b0, 21'h00300, 32'h0000_00BB);
        @(negedge clk);
        check("post_rst_addr", mmio_addr, 21'h00200);
        @(negedge clk);
        check("post_rst_ack0", m0_ack, 1'b1);
        check("post_rst_ack1", m1_ack, 1'b0);
        drive_master(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);

`ifdef MMIO_ARB_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        for (int i = 0; i < 5; i++)
            txn($sformatf("st_m0_%0d", i), 1'b0, 1'b1, 1'b0, 21'(i), 32'(i), 32'h0);
        for (int i = 0; i < 3; i++)
            txn($sformatf("st_m1_%0d", i), 1'b1, 1'b1, 1'b0, 21'(i), 32'(i), 32'h0);
        @(negedge clk);
        check("stats_m0", m0_count, 16'd5);
        check("stats_m1", m1_count, 16'd3);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("stats_clr_m0", m0_count, 16'd0);
        check("stats_clr_m1", m1_count, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
